// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with bounded bursts that feeds one UART transmitter
// from NUM_REQ byte sources through a single-entry holding register.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_error,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_error,
  input  logic                          tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, LOADED} state_t;

  state_t         state, state_next;
  logic [BW-1:0]  burst_cnt;
  logic           cont;
  logic           any_req;
  logic           keep;
  logic           hit;
  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;
  int             base;

  assign busy = (state == LOADED);

  // Handshake: a byte moves to tx_asm in a cycle where tx_valid && tx_ready;
  // a requester's byte is captured in a cycle where req_valid[i] && req_ready[i].
  always_comb begin
    state_next = state;
    req_ready  = '0;
    hit        = 1'b0;
    win        = grant_id;
    cand       = '0;
    any_req    = |req_valid;
    keep       = cont && (burst_cnt < BW'(MAX_BURST)) && req_valid[grant_id];
    // burst_cnt is zero only straight out of reset, where the search starts at 0.
    base       = (burst_cnt == '0) ? 0 : (int'(grant_id) + 1) % NUM_REQ;
    if (!keep) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = IDW'((base + k) % NUM_REQ);
        if (!hit && req_valid[cand]) begin
          hit = 1'b1;
          win = cand;
        end
      end
    end
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = LOADED;
          if (rst_n) req_ready[win] = 1'b1;
        end
      end
      LOADED: begin
        if (tx_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      tx_error  <= 1'b0;
      grant_id  <= '0;
      burst_cnt <= '0;
      cont      <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (any_req) begin
          tx_valid  <= 1'b1;
          tx_data   <= req_data[win*DATA_WIDTH +: DATA_WIDTH];
          tx_error  <= req_error[win];
          grant_id  <= win;
          burst_cnt <= keep ? burst_cnt + BW'(1) : BW'(1);
          cont      <= 1'b1;
        end else begin
          // An idle gap ends the burst; the owner must win the search again.
          cont <= 1'b0;
        end
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table plus round-robin, burst,
// backpressure and reset sequences.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_error;
  logic        tx_ready;

  logic [3:0]  req_ready, rr_req_ready;
  logic        tx_valid, rr_tx_valid;
  logic [7:0]  tx_data, rr_tx_data;
  logic        tx_error, rr_tx_error;
  logic [1:0]  grant_id, rr_grant_id;
  logic        busy, rr_busy;

  int checks;
  int errors;

  uart_tx_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_error(req_error), .req_ready(req_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_error(tx_error), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy)
  );

  uart_tx_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_error(req_error), .req_ready(rr_req_ready), .tx_valid(rr_tx_valid),
    .tx_data(rr_tx_data), .tx_error(rr_tx_error), .tx_ready(tx_ready),
    .grant_id(rr_grant_id), .busy(rr_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  err;
    logic        txr;
    logic [3:0]  e_rr;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic        e_txe;
    logic [1:0]  e_gid;
    logic        e_busy;
  } vec_t;

  vec_t vecs[14];
  logic [1:0] burst_gid[6];

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_error = '0;
    tx_ready  = 1'b1;

    vecs[0]  = '{4'b0000, 32'h0,        4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{4'b0001, 32'h000000FC, 4'b0000, 1'b0, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{4'b0000, 32'h0,        4'b0000, 1'b0, 4'b0000, 1'b1, 8'hFC, 1'b0, 2'd0, 1'b1};
    vecs[3]  = '{4'b0000, 32'h0,        4'b0000, 1'b1, 4'b0000, 1'b1, 8'hFC, 1'b0, 2'd0, 1'b1};
    vecs[4]  = '{4'b0000, 32'h0,        4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[5]  = '{4'b1000, 32'h55000000, 4'b1000, 1'b0, 4'b1000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[6]  = '{4'b0000, 32'h0,        4'b0000, 1'b0, 4'b0000, 1'b1, 8'h55, 1'b1, 2'd3, 1'b1};
    vecs[7]  = '{4'b0000, 32'h0,        4'b0000, 1'b0, 4'b0000, 1'b1, 8'h55, 1'b1, 2'd3, 1'b1};
    vecs[8]  = '{4'b0000, 32'h0,        4'b0000, 1'b1, 4'b0000, 1'b1, 8'h55, 1'b1, 2'd3, 1'b1};
    vecs[9]  = '{4'b0000, 32'h0,        4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0};
    vecs[10] = '{4'b1001, 32'h33000001, 4'b0000, 1'b0, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0};
    vecs[11] = '{4'b1000, 32'h33000001, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h01, 1'b0, 2'd0, 1'b1};
    vecs[12] = '{4'b1000, 32'h33000001, 4'b0000, 1'b0, 4'b1000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[13] = '{4'b0000, 32'h0,        4'b0000, 1'b0, 4'b0000, 1'b1, 8'h33, 1'b0, 2'd3, 1'b1};

    burst_gid[0] = 2'd0; burst_gid[1] = 2'd0; burst_gid[2] = 2'd2;
    burst_gid[3] = 2'd2; burst_gid[4] = 2'd0; burst_gid[5] = 2'd0;

    do_reset();

    // cycle table: single request, error passthrough, burst not resuming
    for (int i = 0; i < 14; i++) begin
      req_valid = vecs[i].valid;
      req_data  = vecs[i].data;
      req_error = vecs[i].err;
      tx_ready  = vecs[i].txr;
      @(negedge clk);
      check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_rr));
      check($sformatf("vec%0d tx_valid", i), 32'(tx_valid), 32'(vecs[i].e_txv));
      check($sformatf("vec%0d grant_id", i), 32'(grant_id), 32'(vecs[i].e_gid));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_txv || i == 0) begin
        check($sformatf("vec%0d tx_data", i), 32'(tx_data), 32'(vecs[i].e_txd));
        check($sformatf("vec%0d tx_error", i), 32'(tx_error), 32'(vecs[i].e_txe));
      end
      tick();
    end

    // pure round-robin on the MAX_BURST=1 instance
    req_valid = '0;
    tx_ready  = 1'b1;
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    req_error = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("rr%0d ready", k), 32'(rr_req_ready), 32'(4'b0001 << (k % 4)));
      check($sformatf("rr%0d idle", k), 32'(rr_tx_valid), 32'd0);
      tick();
      @(negedge clk);
      check($sformatf("rr%0d ready_low", k), 32'(rr_req_ready), 32'd0);
      check($sformatf("rr%0d tx_valid", k), 32'(rr_tx_valid), 32'd1);
      check($sformatf("rr%0d tx_data", k), 32'(rr_tx_data), 32'h10 + 32'(k % 4));
      check($sformatf("rr%0d grant", k), 32'(rr_grant_id), 32'(k % 4));
      tick();
    end

    // bursts of two on the default instance
    req_valid = '0;
    do_reset();
    req_valid = 4'b0101;
    req_data  = 32'h00A200A0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("burst%0d ready", k), 32'(req_ready), 32'(4'b0001 << burst_gid[k]));
      tick();
      @(negedge clk);
      check($sformatf("burst%0d grant", k), 32'(grant_id), 32'(burst_gid[k]));
      check($sformatf("burst%0d tx_data", k), 32'(tx_data), (burst_gid[k] == 2'd0) ? 32'hA0 : 32'hA2);
      tick();
    end

    // backpressure while holding 0xA5 from requester 2
    req_valid = '0;
    do_reset();
    tx_ready  = 1'b0;
    req_valid = 4'b0100;
    req_data  = 32'h00A50000;
    @(negedge clk);
    check("bp capture", 32'(req_ready), 32'b0100);
    tick();
    for (int k = 0; k < 50; k++) begin
      req_data = {8'h00, 8'(k), 16'h0000};
      @(negedge clk);
      check($sformatf("bp%0d tx_valid", k), 32'(tx_valid), 32'd1);
      check($sformatf("bp%0d tx_data", k), 32'(tx_data), 32'hA5);
      check($sformatf("bp%0d no_ready", k), 32'(req_ready), 32'd0);
      tick();
    end
    req_data = 32'h005A0000;
    tx_ready = 1'b1;
    @(negedge clk);
    check("bp handshake tx_valid", 32'(tx_valid), 32'd1);
    check("bp handshake no_ready", 32'(req_ready), 32'd0);
    tick();
    tx_ready = 1'b0;
    @(negedge clk);
    check("bp gap busy", 32'(busy), 32'd0);
    check("bp gap tx_valid", 32'(tx_valid), 32'd0);
    check("bp gap capture", 32'(req_ready), 32'b0100);
    tick();
    @(negedge clk);
    check("bp next tx_valid", 32'(tx_valid), 32'd1);
    check("bp next tx_data", 32'(tx_data), 32'h5A);
    check("bp next grant", 32'(grant_id), 32'd2);

    // asynchronous reset while LOADED
    #2;
    rst_n = 1'b0;
    #1;
    check("arst tx_valid", 32'(tx_valid), 32'd0);
    check("arst busy", 32'(busy), 32'd0);
    check("arst grant", 32'(grant_id), 32'd0);
    check("arst req_ready", 32'(req_ready), 32'd0);
    req_valid = 4'b1010;
    req_data  = 32'hB300B100;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("arst first ready", 32'(req_ready), 32'b0010);
    tick();
    @(negedge clk);
    check("arst first data", 32'(tx_data), 32'hB1);
    check("arst first grant", 32'(grant_id), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (`tx_asm`) among NUM_REQ independent byte sources.
- Round-robin arbitration with an optional bounded burst: a requester may keep the grant for up to MAX_BURST consecutive bytes.
- Holds one captured byte in a single-entry holding register and drives it into the transmitter's valid/ready port.
- Sits between client logic and `tx_asm`; `tx_asm`'s own configuration inputs (e.g. `parity_per_byte`) are wired at top level, not through this block.

Parameters:
- DATA_WIDTH, 8: byte width, matching `tx_asm`.
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_BURST, 2: max consecutive bytes granted to one requester, 1..15. Value 1 gives pure round-robin.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte pending.
- req_data  in  NUM_REQ*DATA_WIDTH  byte of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_error  in  NUM_REQ  error-inject flag travelling with requester i's byte.
- req_ready  out  NUM_REQ  one-hot; bit i high marks capture of requester i's byte this cycle.
- tx_valid  out  1  to `tx_asm` valid.
- tx_data  out  DATA_WIDTH  to `tx_asm` data.
- tx_error  out  1  to `tx_asm` error.
- tx_ready  in  1  from `tx_asm` ready.
- grant_id  out  $clog2(NUM_REQ)  index of requester owning the held byte / last owner.
- busy  out  1  high when the holding register is full (state LOADED).

Behaviour:
- Reset (async assert, sync-safe deassert):
  - tx_valid=0, tx_data=0, tx_error=0, busy=0, grant_id=0, req_ready=0.
  - RR pointer=0, burst_cnt=0, state=IDLE.
  - Reset mid-transfer discards the held byte; no partial re-send after reset.
- States: IDLE (holding empty), LOADED (holding full).
- IDLE:
  - If any req_valid: pick winner W, assert req_ready[W] combinationally that cycle.
  - Register req_data[W] into tx_data and req_error[W] into tx_error; set tx_valid=1, grant_id=W, next state LOADED.
  - Latency: capture cycle N -> tx_valid high in cycle N+1.
  - If no req_valid: stay IDLE, req_ready=0.
- Winner selection:
  - If burst_cnt < MAX_BURST and req_valid[grant_id]=1 and the previous capture was from grant_id: W=grant_id, burst_cnt+1.
  - Else: search upward from (grant_id+1) mod NUM_REQ, wrapping; first valid wins; burst_cnt=1.
  - After reset, the search starts at index 0 (requester 0 wins first).
  - A burst that ends because the owner's req_valid drops does not resume; the next capture searches from grant_id+1.
- LOADED:
  - tx_valid, tx_data and tx_error hold stable until tx_valid && tx_ready in the same cycle.
  - In that cycle, tx_valid=0 next cycle and state goes to IDLE.
  - No capture occurs in the handshake cycle: one-cycle minimum gap between bytes, which is negligible against the frame time.
- req_ready is never asserted in LOADED. Requester valid/data changes during LOADED do not affect the held byte.
- Requesters must hold valid and data stable until their req_ready pulse. Dropping valid before the grant is permitted and simply withdraws the request.
- The block must not create a combinational path from tx_ready to req_ready.
- grant_id keeps its value in IDLE. busy == (state==LOADED).

Test Plan:
- Single request: reset, req_valid=4'b0001, req_data[7:0]=8'hFC, error=0.
  - req_ready=4'b0001 for exactly one cycle; tx_valid next cycle with tx_data=8'hFC, tx_error=0.
  - `tx_asm` + `rx_asm` loopback receives 0xFC with no error.
- Round-robin: MAX_BURST=1, all four requesters hold valid with bytes 8'h10..8'h13.
  - Transmit order 0x10, 0x11, 0x12, 0x13, then 0x10 again.
  - Each req_ready pulse is one cycle.
- Burst: MAX_BURST=2, requesters 0 and 2 continuously valid.
  - Grant sequence 0,0,2,2,0,0; grant_id follows.
- Backpressure: hold tx_ready=0 for 50 cycles while LOADED with 8'hA5; change req_data meanwhile.
  - tx_valid=1 and tx_data=8'hA5 stable throughout; no req_ready.
  - Release tx_ready: one handshake, then one IDLE cycle before the next capture.
- Reset mid-operation: assert rst_n=0 while LOADED.
  - tx_valid=0 immediately (asynchronous), busy=0, grant_id=0.
  - After release with req 1 and 3 valid, requester 1 is granted first.
- Error passthrough: requester 3 sends 8'h55 with req_error=1.
  - tx_error=1 alongside tx_data=8'h55 until the handshake.
  - Receiver flags an error.
